// File: rtl/pair_xmit_sched_if.sv
// Handshake bundle between the requester streams / datapath (master side) and the
// pair_xmit_sched burst scheduler (slave side).
interface pair_xmit_sched_if #(
  parameter int NUM_REQ    = 2,
  parameter int ITEM_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            src_vld_i;
  logic [NUM_REQ*ITEM_WIDTH-1:0] src_a_i;
  logic [NUM_REQ*ITEM_WIDTH-1:0] src_b_i;
  logic [NUM_REQ-1:0]            src_last_i;
  logic [NUM_REQ-1:0]            src_rdy_o;
  logic [ITEM_WIDTH-1:0]         pair_a_o;
  logic [ITEM_WIDTH-1:0]         pair_b_o;
  logic                          pair_vld_o;
  logic                          pair_rdy_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            burst_done_o;
  logic [CNT_WIDTH-1:0]          beat_cnt_o;
  logic [CNT_WIDTH-1:0]          burst_cnt_o;
  logic                          err_o;

  modport master (
    output src_vld_i, src_a_i, src_b_i, src_last_i, pair_rdy_i,
    input  src_rdy_o, pair_a_o, pair_b_o, pair_vld_o, gnt_o,
           burst_done_o, beat_cnt_o, burst_cnt_o, err_o
  );

  modport slave (
    input  src_vld_i, src_a_i, src_b_i, src_last_i, pair_rdy_i,
    output src_rdy_o, pair_a_o, pair_b_o, pair_vld_o, gnt_o,
           burst_done_o, beat_cnt_o, burst_cnt_o, err_o
  );
endinterface

// File: rtl/pair_xmit_sched.sv
// Burst-granular round-robin scheduler sharing one registered A/B pair output stage.
// Optional stall timeout / burst abort enabled by defining PAIR_SCHED_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | no grant; picks next valid requester at/after the pointer
//  XFER  | one requester granted; pairs flow until its last pair is taken
module pair_xmit_sched #(
  parameter int NUM_REQ    = 2,
  parameter int ITEM_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  pair_xmit_sched_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("pair_xmit_sched: NUM_REQ must be 2..8 and TIMEOUT must be >= 1");
  end

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    ptr_mask_q, ptr_mask_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [ITEM_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  out_vld_q, out_vld_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d, burst_q, burst_d;
  logic                  err_q, err_d;

  logic                  out_free, accept, last_beat, abort;
  logic [NUM_REQ-1:0]    rdy, req_hi, cand, pick, ptr_after_gnt;
  logic [ITEM_WIDTH-1:0] sel_a, sel_b;

  // The pointer is kept as a mask of requesters at or above it; an empty mask means wrap to 0.
  assign out_free      = !out_vld_q || bus.pair_rdy_i;
  assign rdy           = (state_q == XFER && out_free) ? gnt_q : '0;
  assign accept        = |(bus.src_vld_i & rdy);
  assign last_beat     = |(bus.src_last_i & gnt_q);
  assign req_hi        = bus.src_vld_i & ptr_mask_q;
  assign cand          = (|req_hi) ? req_hi : bus.src_vld_i;
  assign pick          = cand & (-cand);
  assign ptr_after_gnt = ~(gnt_q | (gnt_q - NUM_REQ'(1)));

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt_q[r]) begin
        sel_a = sel_a | bus.src_a_i[r*ITEM_WIDTH +: ITEM_WIDTH];
        sel_b = sel_b | bus.src_b_i[r*ITEM_WIDTH +: ITEM_WIDTH];
      end
    end
  end

`ifdef PAIR_SCHED_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 gvld;

  assign gvld  = |(bus.src_vld_i & gnt_q);
  assign abort = (state_q == XFER) && !gvld && (stall_q == CNT_WIDTH'(TIMEOUT));

  always_comb begin
    stall_d = stall_q;
    if (state_q != XFER || accept || abort) stall_d = '0;
    else if (!gvld)                          stall_d = stall_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) stall_q <= '0;
    else         stall_q <= stall_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_mask_d = ptr_mask_q;
    done_d     = '0;
    err_d      = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    out_vld_d  = out_vld_q;
    beat_d     = beat_q;
    burst_d    = burst_q;

    if (accept) begin
      a_d       = sel_a;
      b_d       = sel_b;
      out_vld_d = 1'b1;
    end else if (bus.pair_rdy_i) begin
      out_vld_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (out_free && (|bus.src_vld_i)) begin
          gnt_d   = pick;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          if (beat_q != '1) beat_d = beat_q + CNT_WIDTH'(1);
          if (last_beat) begin
            done_d     = gnt_q;
            burst_d    = burst_q + CNT_WIDTH'(1);
            ptr_mask_d = ptr_after_gnt;
            gnt_d      = '0;
            state_d    = IDLE;
          end
        end else if (abort) begin
          err_d      = 1'b1;
          ptr_mask_d = ptr_after_gnt;
          gnt_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_mask_q <= '1;
      done_q     <= '0;
      err_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      out_vld_q  <= 1'b0;
      beat_q     <= '0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_mask_q <= ptr_mask_d;
      done_q     <= done_d;
      err_q      <= err_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_vld_q  <= out_vld_d;
      beat_q     <= beat_d;
      burst_q    <= burst_d;
    end
  end

  assign bus.src_rdy_o    = rdy;
  assign bus.pair_a_o     = a_q;
  assign bus.pair_b_o     = b_q;
  assign bus.pair_vld_o   = out_vld_q;
  assign bus.gnt_o        = gnt_q;
  assign bus.burst_done_o = done_q;
  assign bus.beat_cnt_o   = beat_q;
  assign bus.burst_cnt_o  = burst_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_pair_xmit_sched.sv
// Directed bench for pair_xmit_sched: per-requester stimulus queues feed a driver, accepted
// pairs go to a scoreboard that is checked against the datapath output.
module tb_pair_xmit_sched;
  localparam int NR = 2;
  localparam int IW = 8;
  localparam int CW = 16;
  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  pair_xmit_sched_if #(.NUM_REQ(NR), .ITEM_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  pair_xmit_sched #(.NUM_REQ(NR), .ITEM_WIDTH(IW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  typedef struct packed {logic [IW-1:0] a; logic [IW-1:0] b; logic last;} item_t;
  typedef struct packed {logic [IW-1:0] a; logic [IW-1:0] b;} pair_t;

  item_t          q0[$];
  item_t          q1[$];
  pair_t          sb[$];
  logic [IW-1:0]  out_log[$];
  logic [NR-1:0]  gnt_hist[$];

  int ncmp = 0, nerr = 0;
  int cyc = 0, n_out = 0, n_done0 = 0, n_done1 = 0, n_err = 0, n_hold = 0;
  int rdy_mode = 0;
  int lat_start = 0, lat_obs = -1, first_out_cyc = 0, last_out_cyc = 0;
  bit lat_arm = 0, lat_wait = 0, span_arm = 0;
  bit held_vld = 0;
  logic [IW-1:0] held_a, held_b;
  logic [NR-1:0] gnt_prev = '0, gnt_at_done1 = '1, rdy_at_done1 = '1, gnt_at_err = '1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int r, input int n, input int a0, input int b0,
                            input int bstep, input bit with_last);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.a    = IW'(a0 + i);
      it.b    = IW'(b0 + bstep * i);
      it.last = with_last && (i == n - 1);
      if (r == 0) q0.push_back(it);
      else        q1.push_back(it);
    end
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || bus.pair_vld_o) && k < limit) begin
      @(posedge clk_i); #1;
      k++;
    end
    check({tag, "_drain_in_time"}, 32'(k < limit), 32'd1);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    q0.delete(); q1.delete(); sb.delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  // Driver presents queue heads at the falling edge; 2 ns later the handshakes that the next
  // rising edge will perform are evaluated and scored.
  always @(negedge clk_i) begin
    pair_t p;
    cyc++;
    if (q0.size() != 0) begin
      bus.src_vld_i[0] = 1'b1; bus.src_a_i[IW-1:0] = q0[0].a;
      bus.src_b_i[IW-1:0] = q0[0].b; bus.src_last_i[0] = q0[0].last;
    end else begin
      bus.src_vld_i[0] = 1'b0; bus.src_last_i[0] = 1'b0;
    end
    if (q1.size() != 0) begin
      bus.src_vld_i[1] = 1'b1; bus.src_a_i[2*IW-1:IW] = q1[0].a;
      bus.src_b_i[2*IW-1:IW] = q1[0].b; bus.src_last_i[1] = q1[0].last;
    end else begin
      bus.src_vld_i[1] = 1'b0; bus.src_last_i[1] = 1'b0;
    end
    bus.pair_rdy_i = (rdy_mode == 0) ? 1'b1 : ~bus.pair_rdy_i;
    if (lat_arm && (|bus.src_vld_i)) begin
      lat_start = cyc; lat_arm = 0; lat_wait = 1;
    end
    #2;
    if (reset_i) begin
      held_vld = 0;
      gnt_prev = '0;
    end else begin
      check("src_rdy_onehot0", 32'($onehot0(bus.src_rdy_o)), 32'd1);
      check("gnt_onehot0", 32'($onehot0(bus.gnt_o)), 32'd1);
      if (held_vld) begin
        n_hold++;
        check("hold_vld", 32'(bus.pair_vld_o), 32'd1);
        check("hold_a", 32'(bus.pair_a_o), 32'(held_a));
        check("hold_b", 32'(bus.pair_b_o), 32'(held_b));
      end
      held_vld = bus.pair_vld_o && !bus.pair_rdy_i;
      held_a   = bus.pair_a_o;
      held_b   = bus.pair_b_o;
      if (bus.src_vld_i[0] && bus.src_rdy_o[0] && q0.size() != 0) begin
        sb.push_back({q0[0].a, q0[0].b});
        void'(q0.pop_front());
      end
      if (bus.src_vld_i[1] && bus.src_rdy_o[1] && q1.size() != 0) begin
        sb.push_back({q1[0].a, q1[0].b});
        void'(q1.pop_front());
      end
      if (lat_wait && bus.pair_vld_o) begin
        lat_obs = cyc - lat_start; lat_wait = 0;
      end
      if (bus.pair_vld_o && bus.pair_rdy_i) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          p = sb.pop_front();
          check("pair_a", 32'(bus.pair_a_o), 32'(p.a));
          check("pair_b", 32'(bus.pair_b_o), 32'(p.b));
        end
        out_log.push_back(bus.pair_a_o);
        n_out++;
        last_out_cyc = cyc;
        if (span_arm) begin first_out_cyc = cyc; span_arm = 0; end
      end
      if (bus.burst_done_o[0]) n_done0++;
      if (bus.burst_done_o[1]) begin
        n_done1++; gnt_at_done1 = bus.gnt_o; rdy_at_done1 = bus.src_rdy_o;
      end
      if (bus.err_o) begin n_err++; gnt_at_err = bus.gnt_o; end
      if (bus.gnt_o != '0 && bus.gnt_o != gnt_prev) gnt_hist.push_back(bus.gnt_o);
      gnt_prev = bus.gnt_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_out, b_d0, b_d1, b_hold, k;
    logic [IW-1:0] exp_ord[12];
    reset_i = 1'b1;
    bus.src_vld_i = '0; bus.src_a_i = '0; bus.src_b_i = '0; bus.src_last_i = '0;
    bus.pair_rdy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_gnt", 32'(bus.gnt_o), 32'd0);
    check("rst_pair_vld", 32'(bus.pair_vld_o), 32'd0);
    check("rst_src_rdy", 32'(bus.src_rdy_o), 32'd0);
    check("rst_beat", 32'(bus.beat_cnt_o), 32'd0);
    check("rst_burst", 32'(bus.burst_cnt_o), 32'd0);
    check("rst_done", 32'(bus.burst_done_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    reset_i = 1'b0;

    // Test 1: 100-pair burst on req0, always ready.
    @(posedge clk_i); #1;
    b_out = n_out; b_d0 = n_done0; lat_arm = 1; span_arm = 1;
    push_burst(0, 100, 0, 0, 2, 1);
    wait_drain("t1", 400);
    check("t1_pairs", 32'(n_out - b_out), 32'd100);
    check("t1_done0", 32'(n_done0 - b_d0), 32'd1);
    check("t1_burst_cnt", 32'(bus.burst_cnt_o), 32'd1);
    check("t1_beat_cnt", 32'(bus.beat_cnt_o), 32'd100);
    // vld seen in cycle 0 -> grant, accept in cycle 1, output valid in cycle 2
    check("t1_latency", 32'(lat_obs), 32'd2);
    check("t1_back_to_back", 32'(last_out_cyc - first_out_cyc), 32'd99);

    // Test 2: both requesters, pointer 0 after reset -> req0, req1, req0.
    do_reset();
    gnt_hist.delete(); out_log.delete();
    @(posedge clk_i); #1;
    push_burst(0, 4, 'h10, 'h90, 1, 1);
    push_burst(0, 4, 'h20, 'hA0, 1, 1);
    push_burst(1, 4, 'h30, 'hB0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      exp_ord[i]     = IW'('h10 + i);
      exp_ord[i + 4] = IW'('h30 + i);
      exp_ord[i + 8] = IW'('h20 + i);
    end
    wait_drain("t2", 200);
    check("t2_grants", 32'(gnt_hist.size()), 32'd3);
    if (gnt_hist.size() >= 3) begin
      check("t2_gnt0", 32'(gnt_hist[0]), 32'd1);
      check("t2_gnt1", 32'(gnt_hist[1]), 32'd2);
      check("t2_gnt2", 32'(gnt_hist[2]), 32'd1);
    end
    check("t2_pairs", 32'(out_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < out_log.size(); i++)
      check("t2_order", 32'(out_log[i]), 32'(exp_ord[i]));
    check("t2_burst_cnt", 32'(bus.burst_cnt_o), 32'd3);

    // Test 3: pair_rdy_i toggles every cycle during a 10-pair burst.
    b_out = n_out; b_d0 = n_done0; b_hold = n_hold;
    rdy_mode = 1;
    push_burst(0, 10, 'h40, 'hC0, 1, 1);
    wait_drain("t3", 200);
    rdy_mode = 0;
    check("t3_pairs", 32'(n_out - b_out), 32'd10);
    check("t3_done0", 32'(n_done0 - b_d0), 32'd1);
    check("t3_stalls_seen", 32'(n_hold > b_hold), 32'd1);
    check("t3_burst_cnt", 32'(bus.burst_cnt_o), 32'd4);

    // Test 4: reset mid-burst after 37 pairs, then req1 alone is granted first.
    @(posedge clk_i); #1;
    b_out = n_out;
    push_burst(0, 100, 0, 'h55, 1, 1);
    k = 0;
    while ((n_out - b_out) < 37 && k < 300) begin
      @(negedge clk_i); #3;
      k++;
    end
    check("t4_reached_37", 32'(k < 300), 32'd1);
    reset_i = 1'b1;
    q0.delete(); q1.delete(); sb.delete();
    #1;
    check("t4_rst_gnt", 32'(bus.gnt_o), 32'd0);
    check("t4_rst_vld", 32'(bus.pair_vld_o), 32'd0);
    check("t4_rst_a", 32'(bus.pair_a_o), 32'd0);
    check("t4_rst_b", 32'(bus.pair_b_o), 32'd0);
    check("t4_rst_rdy", 32'(bus.src_rdy_o), 32'd0);
    check("t4_rst_beat", 32'(bus.beat_cnt_o), 32'd0);
    check("t4_rst_burst", 32'(bus.burst_cnt_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    gnt_hist.delete();
    b_out = n_out;
    @(posedge clk_i); #1;
    push_burst(1, 4, 'h60, 'hE0, 1, 1);
    wait_drain("t4", 100);
    check("t4_first_gnt", 32'(gnt_hist.size() != 0 ? gnt_hist[0] : '0), 32'd2);
    check("t4_pairs", 32'(n_out - b_out), 32'd4);
    check("t4_burst_cnt", 32'(bus.burst_cnt_o), 32'd1);

    // Test 6: single-pair burst on req1.
    b_out = n_out; b_d1 = n_done1;
    push_burst(1, 1, 'h77, 'h88, 1, 1);
    wait_drain("t6", 50);
    check("t6_pairs", 32'(n_out - b_out), 32'd1);
    check("t6_done1", 32'(n_done1 - b_d1), 32'd1);
    check("t6_idle_gnt", 32'(gnt_at_done1), 32'd0);
    check("t6_idle_rdy", 32'(rdy_at_done1), 32'd0);
    check("t6_burst_cnt", 32'(bus.burst_cnt_o), 32'd2);

`ifdef PAIR_SCHED_TIMEOUT_EN
    // Test 5: req0 stalls after 3 pairs, abort hands over to req1.
    gnt_hist.delete();
    b_out = n_out; b_d0 = n_done0;
    push_burst(0, 3, 'h50, 'hD0, 1, 0);
    push_burst(1, 2, 'h70, 'hF0, 1, 1);
    wait_drain("t5", 200);
    check("t5_err_pulses", 32'(n_err), 32'd1);
    check("t5_gnt_at_err", 32'(gnt_at_err), 32'd0);
    check("t5_done0", 32'(n_done0 - b_d0), 32'd0);
    check("t5_burst_cnt", 32'(bus.burst_cnt_o), 32'd3);
    check("t5_grants", 32'(gnt_hist.size()), 32'd2);
    check("t5_next_gnt", 32'(gnt_hist.size() >= 2 ? gnt_hist[1] : '0), 32'd2);
    check("t5_pairs", 32'(n_out - b_out), 32'd5);
`else
    check("err_never", 32'(n_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
